// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the miniRISC fetch path:
//   - XLEN             : architectural address/data width
//   - fetch_state_t    : pc_fetch_unit FSM encoding
//   - addr_sel_t       : address-select codes, common with the address-select mux
//   - pc_advance()     : sequential PC step, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_JUMP   = 2'b00,
    SEL_REG    = 2'b01,
    SEL_BRANCH = 2'b10,
    SEL_ZERO   = 2'b11
  } addr_sel_t;

  // Plain modulo add: 32'hFFFF_FFFF + 1 wraps to 0.
  function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register. Load has priority over increment.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pc <= RESET_PC)
//   load       : take load_addr next cycle
//   load_addr  : redirect target
//   inc        : advance by PC_STEP next cycle
//   pc         : current program counter
// -----------------------------------------------------------------------------
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_addr,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc_advance(pc, PC_STEP);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Owns the PC, fetches instructions over an imem req/ack handshake and hands
// them to decode over a valid/ready handshake. Handles redirects, stalls, halt.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   redirect_valid/sel/addr      : one-cycle redirect from the address-select mux
//   halt                         : stop fetching after the current instruction
//   imem_req/addr, imem_ack/rdata: instruction memory handshake
//   inst_valid, inst, inst_pc    : instruction to decode
//   dec_ready                    : decode accepts when inst_valid & dec_ready
//   halted                       : high once the unit has halted (rst only exit)
//
// Build option PC_FETCH_PERF_EN adds:
//   fetch_cnt[31:0] : delivered instructions (wrapping)
//   kill_cnt[15:0]  : discarded acks (saturating)
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dec_ready,
  output logic        halted
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [15:0] kill_cnt
`endif
);

  fetch_state_t state;
  logic         kill;       // outstanding request targets a stale pc
  logic [31:0]  pc;

  logic ack_fire;           // ack for a request we actually issued
  logic ack_drop;           // ...whose data must be thrown away
  logic ack_take;           // ...whose data goes to decode
  logic handshake;
  logic pc_load;

  // imem_req gates the ack, so a late ack after reset (req still low) is ignored.
  assign ack_fire  = (state == S_REQ) && imem_req && imem_ack;
  assign ack_drop  = ack_fire && (kill || redirect_valid);
  assign ack_take  = ack_fire && !ack_drop;
  assign handshake = inst_valid && dec_ready;
  assign pc_load   = redirect_valid && (state != S_HALT);

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (redirect_addr),
    .inc       (ack_take),
    .pc        (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      kill       <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            // Idle gap (after reset or a discarded ack): issue now, straight
            // at the redirect target if one arrives in this cycle.
            imem_req  <= 1'b1;
            imem_addr <= redirect_valid ? redirect_addr : pc;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            kill     <= 1'b0;
            if (!(kill || redirect_valid)) begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // Address must stay stable while req is high; remember to drop
            // the returning data and refetch from the new pc.
            kill <= 1'b1;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            // Flush; any same-cycle handshake has already been accepted by decode.
            inst_valid <= 1'b0;
            state      <= S_REQ;
            imem_req   <= 1'b1;
            imem_addr  <= redirect_addr;
          end else if (dec_ready) begin
            inst_valid <= 1'b0;
            if (halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              // pc already advanced when the ack was taken.
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
        end

        S_HALT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          halted     <= 1'b1;
        end

        default: begin
          state    <= S_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (handshake) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (ack_drop && (kill_cnt != 16'hFFFF)) begin
        kill_cnt <= kill_cnt + 16'd1;
      end
    end
  end
`else
  // handshake only feeds the performance counters.
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

`ifndef SYNTHESIS
  zero_sel_addr_a : assert property (
    @(posedge clk) disable iff (rst)
      (redirect_valid && (redirect_sel == SEL_ZERO)) |-> (redirect_addr == '0)
  ) else $error("pc_fetch_unit: SEL_ZERO redirect with nonzero address");
`else
  logic [1:0] unused_sel;
  assign unused_sel = redirect_sel;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. Two instances share clk/rst: dut
// (RESET_PC=0) served by a latency-programmable memory responder, and dut_w
// (RESET_PC=32'hFFFF_FFFF) driven by hand to show PC wrap. Inputs change and
// outputs are sampled on the falling edge; a posedge monitor logs taken acks
// and decode handshakes.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        dec_ready;
  logic        halted;
`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [15:0] kill_cnt;
  logic [31:0] w_fetch_cnt;
  logic [15:0] w_kill_cnt;
`endif

  // Second instance signals
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_dec_ready;
  logic        w_halted;

  // Memory responder / manual ack selection
  logic        mem_en;
  int          lat;
  int          resp_cnt;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        man_ack;
  logic [31:0] man_data;

  assign imem_ack   = mem_en ? resp_ack  : man_ack;
  assign imem_rdata = mem_en ? resp_data : man_data;

  logic [31:0] ack_q[$];
  logic [31:0] dpc_q[$];
  logic [31:0] dinst_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dec_ready      (dec_ready),
    .halted         (halted)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .kill_cnt       (kill_cnt)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (1'b0),
    .redirect_sel   (2'b00),
    .redirect_addr  (32'h0),
    .halt           (1'b0),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ack       (w_ack),
    .imem_rdata     (w_rdata),
    .inst_valid     (w_inst_valid),
    .inst           (w_inst),
    .inst_pc        (w_inst_pc),
    .dec_ready      (w_dec_ready),
    .halted         (w_halted)
`ifdef PC_FETCH_PERF_EN
    ,
    .fetch_cnt      (w_fetch_cnt),
    .kill_cnt       (w_kill_cnt)
`endif
  );

  // Ack in the lat-th cycle that req is high; data = A000_0001 + address.
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (!imem_req) begin
      resp_cnt = 0;
    end else begin
      resp_cnt++;
      if (resp_cnt == lat) begin
        resp_ack  = 1'b1;
        resp_data = 32'hA000_0001 + imem_addr;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ack) ack_q.push_back(imem_addr);
      if (inst_valid && dec_ready) begin
        dpc_q.push_back(inst_pc);
        dinst_q.push_back(inst);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_dut(input int l, input logic en, input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_sel   = 2'b00;
    redirect_addr  = '0;
    halt           = 1'b0;
    dec_ready      = 1'b0;
    man_ack        = 1'b0;
    man_data       = '0;
    w_ack          = 1'b0;
    w_rdata        = '0;
    lat            = l;
    mem_en         = en;
    step();
    step();
    ack_q.delete();
    dpc_q.delete();
    dinst_q.delete();
    dec_ready = rdy;
    rst       = 1'b0;
  endtask

  task automatic wait_deliv(input int n, input int budget, input string tag);
    int k = 0;
    while (dpc_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (dpc_q.size() < n) check(tag, dpc_q.size(), n);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int k = 0;
    while (!imem_req && k < budget) begin
      step();
      k++;
    end
    if (!imem_req) check(tag, imem_req, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w_dec_ready = 1'b1;
    reset_dut(1, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    // Reset values while rst is held
    check("rst_req",    imem_req,   1'b0);
    check("rst_addr",   imem_addr,  32'h0);
    check("rst_valid",  inst_valid, 1'b0);
    check("rst_inst",   inst,       32'h0);
    check("rst_pc",     inst_pc,    32'h0);
    check("rst_halted", halted,     1'b0);
    check("rst_w_addr", w_addr,     32'hFFFF_FFFF);

    // ---- Sequential fetch, ack latency 1, decode always ready ----
    reset_dut(1, 1'b1, 1'b1);
    step();
    check("first_req",  imem_req,  1'b1);
    check("first_addr", imem_addr, 32'h0);
    // PC wrap on the second instance
    check("w_first_req",  w_req,  1'b1);
    check("w_first_addr", w_addr, 32'hFFFF_FFFF);
    w_ack   = 1'b1;
    w_rdata = 32'h1111_1111;
    step();
    w_ack = 1'b0;
    check("w_valid",  w_inst_valid, 1'b1);
    check("w_inst",   w_inst,       32'h1111_1111);
    check("w_pc",     w_inst_pc,    32'hFFFF_FFFF);
    step();
    check("w_wrap_req",  w_req,  1'b1);
    check("w_wrap_addr", w_addr, 32'h0);

    wait_deliv(4, 40, "seq_timeout");
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < dpc_q.size()) begin
        check($sformatf("seq_ack_addr%0d", i), ack_q[i],   32'(i));
        check($sformatf("seq_inst_pc%0d", i),  dpc_q[i],   32'(i));
        check($sformatf("seq_inst%0d", i),     dinst_q[i], 32'hA000_0001 + 32'(i));
      end
    end

    // ---- Stall: decode not ready for 5 cycles ----
    begin
      int k = 0;
      while (!inst_valid && k < 10) begin
        step();
        k++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", inst_valid, 1'b1);
      check("stall_pc",    inst_pc,    32'h4);
      check("stall_inst",  inst,       32'hA000_0005);
      check("stall_req",   imem_req,   1'b0);
      step();
    end

    // ---- Redirect while a slow (latency 4) fetch is pending ----
    lat       = 4;
    dec_ready = 1'b1;
    wait_req(10, "redir_req_timeout");
    check("next_fetch_addr", imem_addr, 32'h5);
    redirect_valid = 1'b1;
    redirect_sel   = 2'b01;
    redirect_addr  = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    check("kill_addr_stable", imem_addr, 32'h5);
    check("kill_req_held",    imem_req,  1'b1);
    wait_deliv(6, 40, "redir_timeout");
    if (dpc_q.size() >= 6) begin
      check("redir_inst_pc", dpc_q[5],   32'h40);
      check("redir_inst",    dinst_q[5], 32'hA000_0041);
    end
    if (ack_q.size() >= 7) begin
      check("stale_ack_addr", ack_q[5], 32'h5);
      check("redir_ack_addr", ack_q[6], 32'h40);
    end else begin
      check("redir_ack_count", ack_q.size(), 7);
    end
`ifdef PC_FETCH_PERF_EN
    check("perf_kill_cnt",  kill_cnt,  16'd1);
    check("perf_fetch_cnt", fetch_cnt, dpc_q.size());
`endif

    // ---- Redirect and halt in the same cycle: redirect wins ----
    reset_dut(1, 1'b1, 1'b0);
    begin
      int k = 0;
      while (!inst_valid && k < 10) begin
        step();
        k++;
      end
    end
    check("hr_hold_pc", inst_pc, 32'h0);
    halt           = 1'b1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_sel   = 2'b00;
    redirect_addr  = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    check("hr_not_halted", halted,    1'b0);
    check("hr_req",        imem_req,  1'b1);
    check("hr_addr",       imem_addr, 32'h80);
    begin
      int k = 0;
      while (!halted && k < 20) begin
        step();
        k++;
      end
    end
    check("hr_halted",  halted,       1'b1);
    check("hr_ndeliv",  dpc_q.size(), 2);
    if (dpc_q.size() == 2) check("hr_last_pc", dpc_q[1], 32'h80);
    redirect_valid = 1'b1;
    redirect_sel   = 2'b10;
    redirect_addr  = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_no_req",   imem_req,   1'b0);
      check("halt_no_valid", inst_valid, 1'b0);
      check("halt_stays",    halted,     1'b1);
    end

    // ---- Halt during a pending fetch ----
    reset_dut(4, 1'b1, 1'b1);
    wait_req(10, "hp_req_timeout");
    halt = 1'b1;
    begin
      int k = 0;
      while (!halted && k < 20) begin
        step();
        k++;
      end
    end
    check("hp_halted", halted,       1'b1);
    check("hp_ndeliv", dpc_q.size(), 1);
    if (dpc_q.size() == 1) begin
      check("hp_pc",   dpc_q[0],   32'h0);
      check("hp_inst", dinst_q[0], 32'hA000_0001);
    end
    step();
    step();
    check("hp_no_req",  imem_req,     1'b0);
    check("hp_nacks",   ack_q.size(), 1);

    // ---- Reset in the middle of a request; late ack ignored ----
    reset_dut(1, 1'b0, 1'b1);
    step();
    man_ack  = 1'b1;
    man_data = 32'h5555_5555;
    step();
    man_ack = 1'b0;
    check("mr_valid", inst_valid, 1'b1);
    step();
    check("mr_req",  imem_req,  1'b1);
    check("mr_addr", imem_addr, 32'h1);
    check("mr_inst", inst,      32'h5555_5555);
    rst = 1'b1;
    #1;
    check("mr_rst_req",   imem_req,   1'b0);
    check("mr_rst_addr",  imem_addr,  32'h0);
    check("mr_rst_valid", inst_valid, 1'b0);
    check("mr_rst_inst",  inst,       32'h0);
    check("mr_rst_pc",    inst_pc,    32'h0);
`ifdef PC_FETCH_PERF_EN
    check("mr_rst_fetch_cnt", fetch_cnt, 32'h0);
`endif
    step();
    rst      = 1'b0;
    man_ack  = 1'b1;
    man_data = 32'hDEAD_BEEF;
    step();
    man_ack = 1'b0;
    check("late_valid", inst_valid, 1'b0);
    check("late_inst",  inst,       32'h0);
    check("late_req",   imem_req,   1'b1);
    check("late_addr",  imem_addr,  32'h0);
`ifdef PC_FETCH_PERF_EN
    check("late_kill_cnt", kill_cnt, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and drives instruction-memory reads for the miniRISC core. It consumes the next-address value built by the address-select mux, i.e. the jump, register, branch or zero target plus its 2-bit select.
- Issues fetches over a req/ack handshake and presents each fetched instruction and its PC to decode over a valid/ready handshake.
- Handles redirects, stalls and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 1, sequential increment (word-addressed instruction memory).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  one-cycle pulse: take redirect_addr as next PC.
- redirect_sel  in  2  address-select code accompanying the redirect (00 jump, 01 register, 10 branch, 11 zero).
- redirect_addr  in  32  output of the address-select mux.
- halt  in  1  level; stop fetching after the current transaction.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address, stable while imem_req is high.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- dec_ready  in  1  decode accepts when inst_valid and dec_ready are both high.
- halted  out  1  high in S_HALT.

Behaviour:
- Reset (async): pc=RESET_PC, state=S_REQ, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0, kill=0. imem_req rises on the first clock after rst deasserts.
- State S_REQ:
  - imem_req=1, imem_addr=pc.
  - On ack with kill=0: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+PC_STEP (mod 2^32, wraps 32'hFFFF_FFFF->0), go to S_HOLD.
  - On ack with kill=1: discard the data, clear kill, stay in S_REQ. The request reissues at the updated pc the next cycle; imem_req drops for exactly one cycle between transactions.
- State S_HOLD:
  - imem_req=0; inst, inst_pc and inst_valid are held stable.
  - On dec_ready: inst_valid<=0, go to S_REQ, or S_HALT if halt is high.
  - Minimum fetch-to-fetch spacing is 2 cycles at ack latency 1.
- State S_HALT: imem_req=0, inst_valid=0, halted=1. Left only via rst.
- Redirect in any non-halt state:
  - pc<=redirect_addr next cycle.
  - Redirect in S_REQ with no ack in the same cycle: kill<=1, and imem_addr stays at the old pc until the ack arrives.
  - Redirect in S_REQ in the same cycle as an ack: the ack data is discarded and kill stays 0.
  - Redirect in S_HOLD: inst_valid<=0 (flush), go to S_REQ.
  - Redirect in the same cycle as a dec_ready handshake: the handshake completes and pc still takes redirect_addr.
  - redirect_sel=11 requires redirect_addr=0. A mismatch is flagged by a simulation-only assertion; RTL uses redirect_addr regardless.
- halt while in S_REQ: the outstanding request completes and its instruction is delivered, then S_HALT after the handshake. Redirect has priority over halt in the same cycle.
- Reset mid-transaction: all state is cleared immediately. A late ack after reset is ignored, because imem_req=0 and the state is S_REQ with no outstanding request until the first clock.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - Adds output fetch_cnt[31:0], counting delivered instructions (valid&ready handshakes), reset 0, wraps.
  - Adds output kill_cnt[15:0], counting discarded acks, saturating at 16'hFFFF.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package fetch_pkg:
  - State encoding S_REQ=2'd0, S_HOLD=2'd1, S_HALT=2'd2.
  - Address-select codes SEL_JUMP=2'b00, SEL_REG=2'b01, SEL_BRANCH=2'b10, SEL_ZERO=2'b11, shared with the address-select mux.
  - XLEN=32.
- Sub-module pc_reg (PC register with load/increment/reset value) is natural; the FSM and handshakes stay in the top module.

Test Plan:
- Reset, ack latency 1, dec_ready=1: imem_addr sequence 0,1,2,3; inst_pc matches the address; inst equals the returned data (e.g. 32'hA000_0001 at addr 0).
- Redirect to 32'h0000_0040 (sel=01) while a request is pending with ack delayed 3 cycles: stale data is not presented, next imem_addr=32'h40, and delivered inst_pc=32'h40.
- Hold dec_ready=0 for 5 cycles in S_HOLD: inst and inst_pc stay stable, imem_req=0; after ready, the next fetch uses pc+1.
- RESET_PC=32'hFFFF_FFFF: first fetch at 32'hFFFF_FFFF, second at 32'h0000_0000.
- halt asserted during a pending fetch: that instruction is delivered, then halted=1 and no further imem_req; a redirect in the same cycle as halt wins.
- Assert rst mid-request with ack arriving the next cycle: outputs return to reset values immediately and the ack is ignored. With PC_FETCH_PERF_EN, fetch_cnt=0 after reset and kill_cnt increments once per discarded ack.
